// File: rtl/key_sched_ctrl.sv
// Iterative AES key-schedule controller. One shared round-key generator
// stage is launched once per round; the eleven round keys are kept in a
// local key store that is read through a combinational random-access port.
module key_sched_ctrl #(
    parameter int KEY_L     = 128,
    parameter int NO_ROUNDS = 10,
    parameter int TIMEOUT   = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_valid_in,
    input  logic [KEY_L-1:0] cipher_key,
    output logic             key_ready,
    output logic             rkg_valid_in,
    output logic [31:0]      rkg_rcon,
    output logic [KEY_L-1:0] rkg_key_in,
    input  logic [KEY_L-1:0] rkg_key_out,
    input  logic             rkg_valid_out,
    input  logic [3:0]       rd_round,
    output logic [KEY_L-1:0] rd_key,
    output logic             keys_ready,
    output logic             busy,
    output logic             err
);

    localparam int               CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [3:0]       LAST_ROUND = 4'(NO_ROUNDS);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state;
    logic [3:0]         round;
    logic [CNT_W-1:0]   wait_cnt;
    logic [KEY_L-1:0]   slots [0:NO_ROUNDS];

    // Round constant for launch number idx (0-based), placed in the top byte.
    function automatic logic [31:0] rcon_of(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd0:    rc = 8'h01;
            4'd1:    rc = 8'h02;
            4'd2:    rc = 8'h04;
            4'd3:    rc = 8'h08;
            4'd4:    rc = 8'h10;
            4'd5:    rc = 8'h20;
            4'd6:    rc = 8'h40;
            4'd7:    rc = 8'h80;
            4'd8:    rc = 8'h1b;
            4'd9:    rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return {rc, 24'h000000};
    endfunction

    // Expansion FSM: launches the generator, waits for its result, fills the key store.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            round        <= 4'd0;
            wait_cnt     <= '0;
            key_ready    <= 1'b1;
            keys_ready   <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
            rkg_valid_in <= 1'b0;
            rkg_rcon     <= 32'h0;
            rkg_key_in   <= '0;
            // NOTE: the store is cleared on reset because stale keys must
            // never be readable after an abort; this makes it flops, not RAM.
            for (int i = 0; i <= NO_ROUNDS; i++) begin
                slots[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (key_valid_in) begin
                        slots[0]     <= cipher_key;
                        round        <= 4'd1;
                        keys_ready   <= 1'b0;
                        err          <= 1'b0;
                        key_ready    <= 1'b0;
                        busy         <= 1'b1;
                        rkg_valid_in <= 1'b1;
                        rkg_key_in   <= cipher_key;
                        rkg_rcon     <= rcon_of(4'd0);
                        state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Strobe lasts one cycle; key and rcon stay put through WAIT.
                    rkg_valid_in <= 1'b0;
                    wait_cnt     <= '0;
                    state        <= S_WAIT;
                end
                S_WAIT: begin
                    if (rkg_valid_out) begin
                        slots[round] <= rkg_key_out;
                        if (round == LAST_ROUND) begin
                            state <= S_DONE;
                        end else begin
                            // Next launch chains from the key just produced.
                            round        <= round + 4'd1;
                            rkg_valid_in <= 1'b1;
                            rkg_key_in   <= rkg_key_out;
                            rkg_rcon     <= rcon_of(round);
                            state        <= S_ISSUE;
                        end
                    end else if (wait_cnt == CNT_LAST) begin
                        // Generator never answered: abandon the schedule.
                        err       <= 1'b1;
                        key_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    keys_ready <= 1'b1;
                    key_ready  <= 1'b1;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Combinational read port; indices past the last round read as zero.
    // NOTE: rd_key gets a default before the conditional so no latch is inferred.
    always_comb begin
        rd_key = '0;
        if (rd_round <= LAST_ROUND) begin
            rd_key = slots[rd_round];
        end
    end

endmodule

// File: doc/key_sched_ctrl.md
# key_sched_ctrl

Iterative key-schedule controller for the AES key expansion path. It accepts a cipher key through a valid/ready handshake and reuses one external round-key generator stage to produce the whole schedule. The stage is driven ten times in sequence, with the matching round constant each time. All eleven round keys (slot 0 holds the cipher key) are kept in an internal key store, and a random-access read port serves them to the cipher datapath. This trades the fully unrolled ten-stage expansion pipeline for one shared stage.

## Interface
- KEY_L, 128, key and round-key width
- NO_ROUNDS, 10, number of generated round keys; the RCON table covers 10 entries
- TIMEOUT, 255, maximum cycles to wait for the generator stage before flagging an error

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- key_valid_in  in  1  cipher key offered
- cipher_key  in  KEY_L  cipher key
- key_ready  out  1  controller can accept a key (state IDLE)
- rkg_valid_in  out  1  one-cycle launch strobe to the generator stage
- rkg_rcon  out  32  round constant for the current launch
- rkg_key_in  out  KEY_L  previous round key fed to the stage
- rkg_key_out  in  KEY_L  generated round key
- rkg_valid_out  in  1  generated key valid
- rd_round  in  4  key-store read index, 0..NO_ROUNDS
- rd_key  out  KEY_L  key-store read data
- keys_ready  out  1  complete schedule held in the store
- busy  out  1  expansion in progress
- err  out  1  generator timeout occurred

## Operation
- States:
  - IDLE: key_ready=1. On key_valid_in, write cipher_key to slot 0, set round=1, clear keys_ready and err, go to ISSUE.
  - ISSUE: for one cycle, drive rkg_valid_in=1, rkg_key_in=slot[round-1] and rkg_rcon=RCON[round-1]. Clear the wait counter and go to WAIT.
  - WAIT: count cycles.
    - On rkg_valid_out, write rkg_key_out to slot[round].
      - If round==NO_ROUNDS, go to DONE.
      - Otherwise increment round and go to ISSUE.
    - If the counter reaches TIMEOUT first, go to IDLE with err=1. keys_ready stays 0.
  - DONE: set keys_ready=1 and go to IDLE in the same transition. DONE lasts one cycle.
- RCON values, index 0..9: 01,02,04,08,10,20,40,80,1b,36, each placed in bits [31:24] with the lower 24 bits zero.
- rkg_key_in and rkg_rcon hold their ISSUE values through WAIT.
- rkg_valid_out is ignored outside WAIT.
- busy=1 in ISSUE, WAIT and DONE.
- The read port is combinational: rd_key=slot[rd_round]. If rd_round > NO_ROUNDS, rd_key=0.
- Reads are always permitted. Data is meaningful only while keys_ready=1.
- A new key accepted in IDLE while keys_ready=1 drops keys_ready in the next cycle. Slot contents are overwritten progressively.
- key_valid_in is ignored while busy (key_ready=0). The key is not queued.

## Timing
- Reset values:
  - State IDLE, round=0.
  - All slots 0.
  - key_ready=1, keys_ready=0, busy=0, err=0.
  - rkg_valid_in=0, rkg_rcon=0, rkg_key_in=0.
- Reset asserted mid-expansion aborts immediately and returns every output to its reset value. Any later rkg_valid_out is ignored.
- Generator latency L ≥ 1: a strobe at cycle c returns rkg_valid_out at c+L.
- Key accepted at edge a: ISSUE is in cycle a+1.
- Each round takes L+1 cycles.
- keys_ready rises at edge a+1+NO_ROUNDS·(L+1). With L=1 that is a+21.
- Timeout: err rises at the edge where the counter reaches TIMEOUT, TIMEOUT cycles after entering WAIT. key_ready returns to 1 at the same edge.
- If rkg_valid_out coincides with the timeout cycle, capture wins and no error is flagged.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c with a one-cycle generator model -> keys_ready at acceptance+21. rd_round=10 returns d014f9a8c9ee2589e13f0cc8b6630ca6. rd_round=0 returns the cipher key.
- Generator model with L=4 -> exactly 10 rkg_valid_in pulses, spaced 5 cycles apart. rkg_rcon sequence is 01000000..36000000. keys_ready at acceptance+51.
- Second key offered while busy -> key_ready=0 and the key is not captured. After completion, offering key 000..0 clears keys_ready next cycle. rd_round=1 then returns 62636363626363636263636362636363.
- Generator model that never responds, TIMEOUT=255 -> err=1 and key_ready=1 at 255 cycles after the first WAIT entry. keys_ready=0. The next accepted key clears err.
- reset pulsed during round 5 -> all outputs at reset values and slots read 0. A fresh key then completes normally.
- rd_round=11..15 -> rd_key=0. Spurious rkg_valid_out pulses in IDLE -> no store write.
